tdm_demux4: RTL and testbench

Time-division 1-to-4 demultiplexer: the receiving end of a 4-slot serial link whose transmit side time-shares one lane between four sources by rotating a 2-bit select. It tracks frame alignment from a sync marker and routes each accepted sample into slot 0..3 by an internal slot counter. It presents each complete frame on four parallel registered outputs with a one-cycle frame strobe. It sits between the serial lane and the per-channel consumers.

---
 rtl/tdm_demux4.sv | 96 +++++++++
 tb/tb_tdm_demux4.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux4.sv
// Receive side of a 4-slot TDM lane: finds frame alignment from the sync marker,
// collects slots 0..2 in holding registers and publishes whole frames on out0..out3.
//
// state | meaning
// HUNT  | waiting for a valid sample with sync; samples without sync are dropped
// RUN   | aligned; samples fill slots in order, slot 3 publishes the frame
module tdm_demux4 #(
   parameter int DW = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] in,
   input  logic          in_valid,
   input  logic          sync,
   output logic [DW-1:0] out0,
   output logic [DW-1:0] out1,
   output logic [DW-1:0] out2,
   output logic [DW-1:0] out3,
   output logic          frame_valid,
   output logic          sync_err,
   output logic [1:0]    slot,
   output logic          locked
);

   localparam logic ST_HUNT = 1'b0;
   localparam logic ST_RUN  = 1'b1;

   logic          r_state;
   logic [1:0]    r_slot;
   logic [DW-1:0] r_hold0;
   logic [DW-1:0] r_hold1;
   logic [DW-1:0] r_hold2;
   logic [DW-1:0] r_out0;
   logic [DW-1:0] r_out1;
   logic [DW-1:0] r_out2;
   logic [DW-1:0] r_out3;
   logic          r_frame_valid;
   logic          r_sync_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_HUNT;
         r_slot        <= 2'd0;
         r_hold0       <= '0;
         r_hold1       <= '0;
         r_hold2       <= '0;
         r_out0        <= '0;
         r_out1        <= '0;
         r_out2        <= '0;
         r_out3        <= '0;
         r_frame_valid <= 1'b0;
         r_sync_err    <= 1'b0;
      end else begin
         r_frame_valid <= 1'b0;
         r_sync_err    <= 1'b0;
         if (in_valid) begin
            if (r_state == ST_HUNT) begin
               if (sync) begin
                  r_hold0 <= in;
                  r_slot  <= 2'd1;
                  r_state <= ST_RUN;
               end
            end else if (sync) begin
               // An early sync drops the partial frame; outputs keep the last full one.
               r_sync_err <= (r_slot != 2'd0);
               r_hold0    <= in;
               r_slot     <= 2'd1;
            end else begin
               case (r_slot)
                  2'd0: r_hold0 <= in;
                  2'd1: r_hold1 <= in;
                  2'd2: r_hold2 <= in;
                  default: begin
                     r_out0        <= r_hold0;
                     r_out1        <= r_hold1;
                     r_out2        <= r_hold2;
                     r_out3        <= in;
                     r_frame_valid <= 1'b1;
                  end
               endcase
               r_slot <= r_slot + 2'd1;
            end
         end
      end
   end

   assign out0        = r_out0;
   assign out1        = r_out1;
   assign out2        = r_out2;
   assign out3        = r_out3;
   assign frame_valid = r_frame_valid;
   assign sync_err    = r_sync_err;
   assign slot        = r_slot;
   assign locked      = (r_state == ST_RUN);

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4 (DW=1): expected frames are queued as samples are driven
// and checked by a negedge monitor whenever frame_valid appears.
module tb_tdm_demux4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [0:0] in = 1'b0;
   logic       in_valid = 1'b0;
   logic       sync = 1'b0;
   logic [0:0] out0, out1, out2, out3;
   logic       frame_valid, sync_err, locked;
   logic [1:0] slot;

   int n_vec = 0;
   int n_err = 0;
   int fv_cnt = 0;
   int se_cnt = 0;
   int cyc = 0;
   int last_fv_cyc = 0;
   int fv_gap = 0;
   logic prev_fv = 1'b0;
   logic [3:0] exp_q[$];

   tdm_demux4 #(.DW(1)) dut (
      .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .sync(sync),
      .out0(out0), .out1(out1), .out2(out2), .out3(out3),
      .frame_valid(frame_valid), .sync_err(sync_err), .slot(slot), .locked(locked)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // scoreboard monitor
   always @(negedge clk) begin
      if (!rst) begin
         n_vec++;
         if (frame_valid && sync_err) begin
            n_err++;
            $display("FAIL fv_se_overlap: frame_valid=%b sync_err=%b, required not both", frame_valid, sync_err);
         end
         if (frame_valid) begin
            fv_cnt++;
            fv_gap = cyc - last_fv_cyc;
            last_fv_cyc = cyc;
            n_vec++;
            if (prev_fv) begin
               n_err++;
               $display("FAIL fv_consecutive: frame_valid high two cycles in a row");
            end
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_frame: got %b%b%b%b, required no frame", out0, out1, out2, out3);
            end else begin
               logic [3:0] e;
               e = exp_q.pop_front();
               if ({out0, out1, out2, out3} !== e) begin
                  n_err++;
                  $display("FAIL frame_data: got %b%b%b%b, required %b", out0, out1, out2, out3, e);
               end
            end
         end
         if (sync_err) se_cnt++;
         prev_fv = frame_valid;
      end else begin
         prev_fv = 1'b0;
      end
   end

   task automatic send(input logic d, input logic sy);
      @(negedge clk);
      in = d; in_valid = 1'b1; sync = sy;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b0; sync = 1'b0; in = 1'b0;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_zero(input string tag);
      n_vec++;
      if ({out0, out1, out2, out3, frame_valid, sync_err, slot, locked} !== 9'b0) begin
         n_err++;
         $display("FAIL %s: outs=%b%b%b%b fv=%b se=%b slot=%0d locked=%b, required all 0",
                  tag, out0, out1, out2, out3, frame_valid, sync_err, slot, locked);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; sync = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_zero("reset_state");
      end
      rst = 1'b0;
   endtask

   task automatic test_reset_lock();
      do_reset();
      send(1'b1, 1'b1);
      n_vec++;
      if (locked !== 1'b1 || slot !== 2'd1) begin
         n_err++;
         $display("FAIL lock_first: locked=%b slot=%0d, required 1 and 1", locked, slot);
      end
      send(1'b0, 1'b0);
      send(1'b1, 1'b0);
      exp_q.push_back(4'b1011);
      send(1'b1, 1'b0);
      n_vec++;
      if (frame_valid !== 1'b1 || slot !== 2'd0 || {out0, out1, out2, out3} !== 4'b1011) begin
         n_err++;
         $display("FAIL lock_frame: fv=%b slot=%0d outs=%b%b%b%b, required 1, 0, 1011",
                  frame_valid, slot, out0, out1, out2, out3);
      end
      idle(1);
   endtask

   task automatic test_hunt_discard();
      int fv0;
      do_reset();
      fv0 = fv_cnt;
      for (int i = 0; i < 3; i++) send(1'b1, 1'b0);
      idle(1);
      n_vec++;
      if (fv_cnt != fv0 || locked !== 1'b0 || slot !== 2'd0) begin
         n_err++;
         $display("FAIL hunt_discard: frames=%0d locked=%b slot=%0d, required 0, 0, 0",
                  fv_cnt - fv0, locked, slot);
      end
      send(1'b0, 1'b1);
      send(1'b1, 1'b0);
      send(1'b0, 1'b0);
      exp_q.push_back(4'b0100);
      send(1'b0, 1'b0);
      idle(1);
      n_vec++;
      if ({out0, out1, out2, out3} !== 4'b0100 || fv_cnt != fv0 + 1) begin
         n_err++;
         $display("FAIL hunt_frame: outs=%b%b%b%b frames=%0d, required 0100 and 1",
                  out0, out1, out2, out3, fv_cnt - fv0);
      end
   endtask

   task automatic test_gaps();
      logic [3:0] d;
      int fv0, se0;
      d = 4'b1001;
      fv0 = fv_cnt; se0 = se_cnt;
      exp_q.push_back(d);
      for (int i = 0; i < 4; i++) begin
         send(d[3-i], (i == 0));
         if (i < 3) begin
            for (int g = 0; g < 2; g++) begin
               idle(1);
               n_vec++;
               if (frame_valid !== 1'b0 || sync_err !== 1'b0) begin
                  n_err++;
                  $display("FAIL gap_quiet: fv=%b se=%b, required 0 0", frame_valid, sync_err);
               end
            end
         end
      end
      n_vec++;
      if (frame_valid !== 1'b1 || {out0, out1, out2, out3} !== d) begin
         n_err++;
         $display("FAIL gap_frame: fv=%b outs=%b%b%b%b, required 1 and %b",
                  frame_valid, out0, out1, out2, out3, d);
      end
      idle(1);
      n_vec++;
      if (fv_cnt != fv0 + 1 || se_cnt != se0) begin
         n_err++;
         $display("FAIL gap_counts: frames=%0d sync_errs=%0d, required 1 and 0",
                  fv_cnt - fv0, se_cnt - se0);
      end
   endtask

   task automatic test_early_sync();
      int se0;
      send(1'b1, 1'b1);
      send(1'b1, 1'b0);
      send(1'b1, 1'b0);
      exp_q.push_back(4'b1111);
      send(1'b1, 1'b0);
      se0 = se_cnt;
      send(1'b0, 1'b1);
      send(1'b0, 1'b0);
      send(1'b1, 1'b1);
      n_vec++;
      if (sync_err !== 1'b1 || slot !== 2'd1 || {out0, out1, out2, out3} !== 4'b1111) begin
         n_err++;
         $display("FAIL early_sync: se=%b slot=%0d outs=%b%b%b%b, required 1, 1, 1111",
                  sync_err, slot, out0, out1, out2, out3);
      end
      send(1'b0, 1'b0);
      send(1'b1, 1'b0);
      n_vec++;
      if ({out0, out1, out2, out3} !== 4'b1111) begin
         n_err++;
         $display("FAIL early_hold: outs=%b%b%b%b, required 1111", out0, out1, out2, out3);
      end
      exp_q.push_back(4'b1010);
      send(1'b0, 1'b0);
      idle(1);
      n_vec++;
      if (se_cnt != se0 + 1 || {out0, out1, out2, out3} !== 4'b1010) begin
         n_err++;
         $display("FAIL early_after: sync_errs=%0d outs=%b%b%b%b, required 1 and 1010",
                  se_cnt - se0, out0, out1, out2, out3);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d;
      int fv0;
      d = 8'b1000_0001;
      fv0 = fv_cnt;
      exp_q.push_back(d[7:4]);
      exp_q.push_back(d[3:0]);
      for (int i = 0; i < 8; i++) send(d[7-i], (i == 0 || i == 4));
      idle(1);
      n_vec++;
      if (fv_cnt != fv0 + 2 || fv_gap != 4) begin
         n_err++;
         $display("FAIL back_to_back: frames=%0d gap=%0d, required 2 and 4", fv_cnt - fv0, fv_gap);
      end
   endtask

   task automatic test_reset_mid();
      int fv0;
      send(1'b1, 1'b1);
      send(1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      check_zero("reset_async");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0; sync = 1'b0;
      fv0 = fv_cnt;
      for (int i = 0; i < 4; i++) send(1'b1, 1'b0);
      idle(2);
      n_vec++;
      if (fv_cnt != fv0 || locked !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_nosync: frames=%0d locked=%b, required 0 and 0", fv_cnt - fv0, locked);
      end
   endtask

   initial begin
      test_reset_lock();
      test_hunt_discard();
      test_gaps();
      test_early_sync();
      test_back_to_back();
      test_reset_mid();
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL frames_missing: %0d expected frames never seen, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
